// File: rtl/arb2_pkg.sv
// arb2_pkg: shared definitions for the two-input round-robin stream arbiter.
//   state_e : arbiter FSM state encodings (IDLE, GRANT_A, GRANT_B)
//   SEL_A/B : mux select values (0 picks source A, 1 picks source B)
package arb2_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_e;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/arb2_datapath.sv
// multiplex_behavior: single-bit 2:1 mux cell (Y = X ? B : A).
//   A, B : data inputs
//   X    : select (0 -> A, 1 -> B)
//   Y    : selected bit
//
// arb2_datapath: WIDTH-wide bit-sliced array of multiplex_behavior cells
// that picks the payload of the granted source for the output register.
//   a_data_i : source A payload
//   b_data_i : source B payload
//   sel_i    : select (SEL_A / SEL_B)
//   data_o   : selected payload
module multiplex_behavior (
  input  logic A,
  input  logic B,
  input  logic X,
  output logic Y
);

  always_comb begin
    Y = A;
    if (X) Y = B;
  end

endmodule

module arb2_datapath
  import arb2_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_data_i,
  input  logic [WIDTH-1:0] b_data_i,
  input  logic             sel_i,
  output logic [WIDTH-1:0] data_o
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    multiplex_behavior u_mux (
      .A (a_data_i[i]),
      .B (b_data_i[i]),
      .X (sel_i),
      .Y (data_o[i])
    );
  end

endmodule

// File: rtl/arb2_stream.sv
// arb2_stream: two-input round-robin valid/ready arbiter with burst limiting
// and a one-entry output register.
//   clk, rst                   : clock, asynchronous active-high reset
//   a_valid/a_ready/a_data     : source A stream
//   b_valid/b_ready/b_data     : source B stream
//   out_valid/out_ready/out_data : registered output stream
//   out_sel                    : origin of the beat in out_data (0=A, 1=B)
module arb2_stream
  import arb2_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] a_data,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [WIDTH-1:0] b_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sel
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             last_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_sel_q;

  logic             out_free;
  logic             a_fire;
  logic             b_fire;
  logic             accept;
  logic             mux_sel;
  logic [WIDTH-1:0] mux_data;
  logic [CNT_W-1:0] cnt_d;
  logic             burst_done;
  logic             own_valid;
  logic             other_valid;
  state_e           other_grant;

  // The output register can take a new beat when empty or draining this cycle.
  assign out_free = !out_valid_q || out_ready;
  assign a_ready  = (state_q == GRANT_A) && out_free;
  assign b_ready  = (state_q == GRANT_B) && out_free;
  assign a_fire   = a_valid && a_ready;
  assign b_fire   = b_valid && b_ready;
  assign accept   = a_fire || b_fire;

  assign mux_sel    = (state_q == GRANT_B) ? SEL_B : SEL_A;
  assign cnt_d      = cnt_q + CNT_W'(1);
  assign burst_done = (cnt_d == BURST_LAST);

  // Valids seen from the point of view of the current grant holder.
  assign own_valid   = (state_q == GRANT_B) ? b_valid : a_valid;
  assign other_valid = (state_q == GRANT_B) ? a_valid : b_valid;
  assign other_grant = (state_q == GRANT_B) ? GRANT_A : GRANT_B;

  arb2_datapath #(.WIDTH(WIDTH)) u_datapath (
    .a_data_i (a_data),
    .b_data_i (b_data),
    .sel_i    (mux_sel),
    .data_o   (mux_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_q      <= SEL_B;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= SEL_A;
    end else begin
      // Output register: load on handshake, drain when consumed, else hold.
      if (accept) begin
        out_valid_q <= 1'b1;
        out_data_q  <= mux_data;
        out_sel_q   <= mux_sel;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (a_valid && b_valid) begin
            state_q <= (last_q == SEL_A) ? GRANT_B : GRANT_A;
          end else if (a_valid) begin
            state_q <= GRANT_A;
          end else if (b_valid) begin
            state_q <= GRANT_B;
          end
        end

        GRANT_A, GRANT_B: begin
          if (accept) begin
            if (burst_done) begin
              // Burst limit reached: yield only if the other side is waiting.
              cnt_q <= '0;
              if (other_valid) begin
                state_q <= other_grant;
                last_q  <= mux_sel;
              end
            end else begin
              cnt_q <= cnt_d;
            end
          end else if (!own_valid) begin
            // Holder went quiet: hand over or fall back to IDLE.
            cnt_q   <= '0;
            last_q  <= mux_sel;
            state_q <= other_valid ? other_grant : IDLE;
          end
          // Otherwise the output is stalled: hold state and count.
        end

        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_arb2_stream.sv
// tb_arb2_stream: scoreboard bench for arb2_stream (WIDTH=8, MAX_BURST=4).
module tb_arb2_stream;
  import arb2_pkg::*;

  localparam int WIDTH     = 8;
  localparam int MAX_BURST = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             a_valid = 1'b0;
  logic             a_ready;
  logic [WIDTH-1:0] a_data = '0;
  logic             b_valid = 1'b0;
  logic             b_ready;
  logic [WIDTH-1:0] b_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] out_data;
  logic             out_sel;

  arb2_stream #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
    .clk       (clk),
    .rst       (rst),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_data    (a_data),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_data    (b_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             sel;
    logic [WIDTH-1:0] data;
  } beat_t;

  beat_t            sb_q[$];
  logic [WIDTH-1:0] a_q[$];
  logic [WIDTH-1:0] b_q[$];
  bit               a_en = 0;
  bit               b_en = 0;
  int               n_chk = 0;
  int               n_pass = 0;
  int               cyc = 0;
  int               beats = 0;
  int               beat_cyc[$];
  bit               watch_b = 0;
  int               bready_hits = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic expect_beat(input logic sel, input logic [WIDTH-1:0] data);
    beat_t e;
    e.sel  = sel;
    e.data = data;
    sb_q.push_back(e);
  endtask

  task automatic refresh();
    a_valid = a_en && (a_q.size() > 0);
    if (a_q.size() > 0) a_data = a_q[0];
    b_valid = b_en && (b_q.size() > 0);
    if (b_q.size() > 0) b_data = b_q[0];
  endtask

  // Main-thread stimulus point, after the driver has updated its sources.
  task automatic drive();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_beats(input int target, input int limit, input string name, output bit ok);
    int k;
    k = 0;
    while (beats < target && k < limit) begin
      @(negedge clk);
      #1;
      k++;
    end
    ok = (beats >= target);
    if (!ok) chk(name, beats, target);
  endtask

  // Source driver: advance a queue after each handshake seen at the falling edge.
  initial begin
    bit fa, fb;
    forever begin
      @(negedge clk);
      fa = a_valid && a_ready;
      fb = b_valid && b_ready;
      @(posedge clk);
      #1;
      if (fa && a_q.size() > 0) void'(a_q.pop_front());
      if (fb && b_q.size() > 0) void'(b_q.pop_front());
      refresh();
    end
  end

  // Monitor: compare every delivered beat against the scoreboard.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        if (watch_b && b_ready) bready_hits++;
        if (out_valid && out_ready) begin
          beat_cyc.push_back(cyc);
          beats++;
          if (sb_q.size() == 0) begin
            chk("unexpected_beat", {23'd0, out_sel, out_data}, 32'hFFFF_FFFF);
          end else begin
            e = sb_q.pop_front();
            chk("beat_data", out_data, e.data);
            chk("beat_sel", out_sel, e.sel);
          end
        end
      end
    end
  end

  initial begin
    int t0, b0, k;
    bit ok;

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sel", out_sel, 0);
    rst = 1'b0;
    drive();

    // Single source A: 0x10..0x15
    drive();
    for (int i = 0; i < 6; i++) begin
      a_q.push_back(8'h10 + 8'(i));
      expect_beat(SEL_A, 8'h10 + 8'(i));
    end
    watch_b = 1;
    bready_hits = 0;
    b0 = beats;
    t0 = cyc;
    a_en = 1;
    refresh();
    wait_beats(b0 + 6, 40, "single_timeout", ok);
    if (ok) begin
      chk("single_latency", beat_cyc[b0], t0 + 3);
      chk("single_contig", beat_cyc[b0+5] - beat_cyc[b0], 5);
    end
    watch_b = 0;
    chk("single_b_ready_low", bready_hits, 0);
    a_en = 0;
    repeat (3) drive();

    // Burst limit: A granted first, B joins one cycle later
    drive();
    for (int i = 0; i < 8; i++) begin
      a_q.push_back(8'hA0 + 8'(i));
      b_q.push_back(8'hB0 + 8'(i));
    end
    for (int i = 0; i < 4; i++) expect_beat(SEL_A, 8'hA0 + 8'(i));
    for (int i = 0; i < 4; i++) expect_beat(SEL_B, 8'hB0 + 8'(i));
    for (int i = 4; i < 8; i++) expect_beat(SEL_A, 8'hA0 + 8'(i));
    for (int i = 4; i < 8; i++) expect_beat(SEL_B, 8'hB0 + 8'(i));
    b0 = beats;
    t0 = cyc;
    a_en = 1;
    refresh();
    drive();
    b_en = 1;
    refresh();
    wait_beats(b0 + 16, 60, "burst_timeout", ok);
    if (ok) begin
      chk("burst_latency", beat_cyc[b0], t0 + 3);
      chk("burst_no_bubble", beat_cyc[b0+15] - beat_cyc[b0], 15);
    end
    a_en = 0;
    b_en = 0;
    repeat (3) drive();

    // Back-pressure: 0x3C held for 5 stalled cycles
    drive();
    out_ready = 1'b0;
    a_q.push_back(8'h3C);
    a_q.push_back(8'h3D);
    expect_beat(SEL_A, 8'h3C);
    expect_beat(SEL_A, 8'h3D);
    b0 = beats;
    a_en = 1;
    refresh();
    k = 0;
    while (!out_valid && k < 10) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("bp_out_valid_rise", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_data", out_data, 8'h3C);
      chk("bp_a_ready", a_ready, 0);
      chk("bp_cnt", 32'(dut.cnt_q), 1);
      @(negedge clk);
      #1;
    end
    drive();
    out_ready = 1'b1;
    wait_beats(b0 + 2, 20, "bp_timeout", ok);
    a_en = 0;
    repeat (3) drive();

    // Early release: A gives up after 2 beats while B waits
    drive();
    a_q.push_back(8'h21);
    a_q.push_back(8'h22);
    b_q.push_back(8'h31);
    b_q.push_back(8'h32);
    b_q.push_back(8'h33);
    expect_beat(SEL_A, 8'h21);
    expect_beat(SEL_A, 8'h22);
    expect_beat(SEL_B, 8'h31);
    expect_beat(SEL_B, 8'h32);
    expect_beat(SEL_B, 8'h33);
    b0 = beats;
    a_en = 1;
    refresh();
    drive();
    b_en = 1;
    refresh();
    k = 0;
    while (!b_ready && k < 20) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("early_b_ready", b_ready, 1);
    chk("early_cnt_restart", 32'(dut.cnt_q), 0);
    wait_beats(b0 + 5, 30, "early_timeout", ok);
    if (ok) chk("early_switch_gap", beat_cyc[b0+2] - beat_cyc[b0+1], 2);

    // Idle gap, then a lone B request
    a_en = 0;
    b_en = 0;
    repeat (3) drive();
    chk("idle_out_valid", out_valid, 0);
    chk("idle_state", 32'(dut.state_q), 32'(IDLE));
    drive();
    b_q.push_back(8'h55);
    expect_beat(SEL_B, 8'h55);
    b0 = beats;
    t0 = cyc;
    b_en = 1;
    refresh();
    wait_beats(b0 + 1, 20, "idle_timeout", ok);
    if (ok) chk("idle_b_latency", beat_cyc[b0], t0 + 3);
    b_en = 0;
    repeat (3) drive();

    // Asynchronous reset with a held beat, then a tie after release
    drive();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) a_q.push_back(8'h80 + 8'(i));
    a_en = 1;
    refresh();
    k = 0;
    while (!out_valid && k < 10) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("pre_reset_valid", out_valid, 1);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_a_ready", a_ready, 0);
    chk("arst_b_ready", b_ready, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_out_sel", out_sel, 0);
    chk("arst_state", 32'(dut.state_q), 32'(IDLE));
    drive();
    a_q.delete();
    b_q.delete();
    out_ready = 1'b1;
    a_q.push_back(8'h61);
    b_q.push_back(8'h71);
    expect_beat(SEL_A, 8'h61);
    expect_beat(SEL_B, 8'h71);
    b0 = beats;
    a_en = 1;
    b_en = 1;
    refresh();
    rst = 1'b0;
    wait_beats(b0 + 2, 20, "tie_timeout", ok);
    a_en = 0;
    b_en = 0;
    repeat (3) drive();
    chk("sb_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
